// File: rtl/lcd_mode_sequencer.sv
// lcd_mode_sequencer: per-dot LCD timing controller.
// Counts dots and scanlines. From the position it derives the LCD mode,
// the LY/LYC coincidence flag, the STAT and VBlank interrupt pulses, the
// frame-start pulse and the CPU-side OAM/VRAM access locks.
module lcd_mode_sequencer #(
    parameter int unsigned DOTS_PER_LINE = 456,
    parameter int unsigned OAM_DOTS      = 80,
    parameter int unsigned XFER_DOTS     = 172,
    parameter int unsigned VISIBLE_LINES = 144,
    parameter int unsigned TOTAL_LINES   = 154
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dot_en,
    input  logic       lcd_enable,
    input  logic [3:0] stat_en,
    input  logic [7:0] lyc,
    output logic [7:0] ly,
    output logic [8:0] dot,
    output logic [1:0] mode,
    output logic       coincidence,
    output logic       stat_irq,
    output logic       vblank_irq,
    output logic       frame_start,
    output logic       oam_lock,
    output logic       vram_lock
);

    localparam logic [1:0] MODE_HBLANK = 2'd0;
    localparam logic [1:0] MODE_VBLANK = 2'd1;
    localparam logic [1:0] MODE_OAM    = 2'd2;
    localparam logic [1:0] MODE_XFER   = 2'd3;

    localparam logic [8:0] DOT_LAST    = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] OAM_END     = 9'(OAM_DOTS);
    localparam logic [8:0] XFER_END    = 9'(OAM_DOTS + XFER_DOTS);
    localparam logic [7:0] LY_LAST     = 8'(TOTAL_LINES - 1);
    localparam logic [7:0] LY_VIS_LAST = 8'(VISIBLE_LINES - 1);
    localparam logic [7:0] LY_VBLANK   = 8'(VISIBLE_LINES);

    logic [8:0] dot_r;
    logic [7:0] ly_r;
    logic       en_q_r;
    logic       stat_line_q_r;
    logic       coincidence_r;
    logic       vblank_irq_r;
    logic       frame_start_r;

    logic [8:0] dot_next_s;
    logic [7:0] ly_next_s;
    logic       advance_s;
    logic       line_end_s;
    logic       frame_wrap_s;
    logic       vblank_set_s;
    logic       frame_start_set_s;
    logic [1:0] mode_s;
    logic       stat_line_s;

    // Next dot/line position: cleared while disabled or on the enabling clock,
    // otherwise advanced by one dot on dot_en with line and frame wrap.
    always_comb begin
        dot_next_s = dot_r;
        ly_next_s  = ly_r;
        if (!lcd_enable || !en_q_r) begin
            dot_next_s = 9'd0;
            ly_next_s  = 8'd0;
        end else if (dot_en) begin
            if (dot_r == DOT_LAST) begin
                dot_next_s = 9'd0;
                if (ly_r == LY_LAST) begin
                    ly_next_s = 8'd0;
                end else begin
                    ly_next_s = ly_r + 8'd1;
                end
            end else begin
                dot_next_s = dot_r + 9'd1;
                ly_next_s  = ly_r;
            end
        end else begin
            dot_next_s = dot_r;
            ly_next_s  = ly_r;
        end
    end

    // Event decode for the registered one-clock pulses.
    always_comb begin
        advance_s         = en_q_r & lcd_enable & dot_en;
        line_end_s        = advance_s & (dot_r == DOT_LAST);
        frame_wrap_s      = line_end_s & (ly_r == LY_LAST);
        vblank_set_s      = line_end_s & (ly_r == LY_VIS_LAST);
        frame_start_set_s = lcd_enable & (~en_q_r | frame_wrap_s);
    end

    // Mode from the registered position; a disabled LCD reports HBlank.
    always_comb begin
        mode_s = MODE_HBLANK;
        if (!en_q_r) begin
            mode_s = MODE_HBLANK;
        end else if (ly_r >= LY_VBLANK) begin
            mode_s = MODE_VBLANK;
        end else if (dot_r < OAM_END) begin
            mode_s = MODE_OAM;
        end else if (dot_r < XFER_END) begin
            mode_s = MODE_XFER;
        end else begin
            mode_s = MODE_HBLANK;
        end
    end

    // Combined STAT source line, held low while the LCD is disabled.
    always_comb begin
        stat_line_s = 1'b0;
        if (en_q_r) begin
            stat_line_s = (stat_en[0] & (mode_s == MODE_HBLANK)) |
                          (stat_en[1] & (mode_s == MODE_VBLANK)) |
                          (stat_en[2] & (mode_s == MODE_OAM))    |
                          (stat_en[3] & coincidence_r);
        end else begin
            stat_line_s = 1'b0;
        end
    end

    // State registers: position, enable history, STAT edge memory and pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            dot_r         <= 9'd0;
            ly_r          <= 8'd0;
            en_q_r        <= 1'b0;
            stat_line_q_r <= 1'b0;
            coincidence_r <= 1'b0;
            vblank_irq_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            dot_r         <= dot_next_s;
            ly_r          <= ly_next_s;
            en_q_r        <= lcd_enable;
            stat_line_q_r <= stat_line_s;
            coincidence_r <= (ly_next_s == lyc);
            vblank_irq_r  <= vblank_set_s;
            frame_start_r <= frame_start_set_s;
        end
    end

    assign ly          = ly_r;
    assign dot         = dot_r;
    assign mode        = mode_s;
    assign coincidence = coincidence_r;
    // Rising edge of the STAT line only: a source taking over while another
    // is still active keeps the line high and raises no new request.
    assign stat_irq    = stat_line_s & ~stat_line_q_r;
    assign vblank_irq  = vblank_irq_r;
    assign frame_start = frame_start_r;
    assign oam_lock    = (mode_s == MODE_OAM) | (mode_s == MODE_XFER);
    assign vram_lock   = (mode_s == MODE_XFER);

endmodule
